// File: rtl/alu_muldiv_pkg.sv
// Shared types for the iterative multiply/divide unit: operation codes and FSM states.
package alu_muldiv_pkg;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_t;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIXUP
  } mdu_state_t;

endpackage

// File: rtl/alu_muldiv_seq.sv
// Bit-serial multiply/divide: one shift-add or restoring shift-subtract step per clock,
// operating on magnitudes, with the sign correction applied in a final FIXUP cycle.
module alu_muldiv_seq
  import alu_muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  mdu_op_t          op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             zero_o,
  output logic             divz_o
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  mdu_state_t         state_q;
  logic               is_div_q;
  logic               neg_res_q;
  logic               neg_a_q;
  logic [2*WIDTH:0]   work_q;
  logic [WIDTH-1:0]   divisor_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               busy_q, done_q, zero_q, divz_q;
  logic [WIDTH-1:0]   hi_q, lo_q;

  logic               signed_op;
  logic [WIDTH-1:0]   a_abs, b_abs;
  logic [WIDTH:0]     acc, add_sum;
  logic [WIDTH:0]     rem_s;
  logic [WIDTH+1:0]   diff;
  logic [2*WIDTH:0]   work_d;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;
  logic [WIDTH-1:0]   hi_d, lo_d;
  logic               divz_d;

  always_comb begin
    signed_op = (op_i == MDU_MULT) || (op_i == MDU_DIV);
    a_abs     = (signed_op && a_i[WIDTH-1]) ? (WIDTH'(0) - a_i) : a_i;
    b_abs     = (signed_op && b_i[WIDTH-1]) ? (WIDTH'(0) - b_i) : b_i;

    // Multiply: accumulator in the upper half, multiplier shifts out of the bottom.
    acc     = work_q[2*WIDTH:WIDTH];
    add_sum = acc + {1'b0, divisor_q};

    // Divide: shift remainder:dividend left, keep the difference when it does not go negative.
    rem_s = work_q[2*WIDTH-1:WIDTH-1];
    diff  = {1'b0, rem_s} - {2'b00, divisor_q};

    if (is_div_q) begin
      if (diff[WIDTH+1]) work_d = {rem_s, work_q[WIDTH-2:0], 1'b0};
      else               work_d = {diff[WIDTH:0], work_q[WIDTH-2:0], 1'b1};
    end else begin
      work_d = {1'b0, (work_q[0] ? add_sum : acc), work_q[WIDTH-1:1]};
    end

    prod_fix = neg_res_q ? ((2*WIDTH)'(0) - work_q[2*WIDTH-1:0]) : work_q[2*WIDTH-1:0];
    quot_fix = neg_res_q ? (WIDTH'(0) - work_q[WIDTH-1:0]) : work_q[WIDTH-1:0];
    rem_fix  = neg_a_q ? (WIDTH'(0) - work_q[2*WIDTH-1:WIDTH]) : work_q[2*WIDTH-1:WIDTH];

    divz_d = is_div_q && (divisor_q == '0);
    if (is_div_q) begin
      // With a zero divisor the remainder path already reconstructs the original dividend.
      hi_d = rem_fix;
      lo_d = divz_d ? '1 : quot_fix;
    end else begin
      hi_d = prod_fix[2*WIDTH-1:WIDTH];
      lo_d = prod_fix[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_a_q   <= 1'b0;
      work_q    <= '0;
      divisor_q <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      zero_q    <= 1'b0;
      divz_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start_i) begin
            is_div_q  <= op_i[1];
            neg_res_q <= signed_op && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
            neg_a_q   <= signed_op && a_i[WIDTH-1];
            work_q    <= {{(WIDTH+1){1'b0}}, a_abs};
            divisor_q <= b_abs;
            cnt_q     <= CNT_W'(WIDTH);
            busy_q    <= 1'b1;
            state_q   <= CALC;
          end
        end
        CALC: begin
          work_q <= work_d;
          cnt_q  <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) state_q <= FIXUP;
        end
        FIXUP: begin
          hi_q    <= hi_d;
          lo_q    <= lo_d;
          zero_q  <= (lo_d == '0);
          divz_q  <= divz_d;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;
  assign zero_o = zero_q;
  assign divz_o = divz_q;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed vector table plus hand-written sequences for ignored start, back-to-back start and reset abort.
module tb_alu_muldiv_seq;
  import alu_muldiv_pkg::*;

  localparam int W   = 32;
  localparam int LAT = W + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  mdu_op_t       op;
  logic [W-1:0]  a, b;
  logic          busy, done, zero, divz;
  logic [W-1:0]  hi, lo;

  int checks = 0;
  int errors = 0;

  alu_muldiv_seq #(.WIDTH(W)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .start_i(start),
    .op_i   (op),
    .a_i    (a),
    .b_i    (b),
    .busy_o (busy),
    .done_o (done),
    .hi_o   (hi),
    .lo_o   (lo),
    .zero_o (zero),
    .divz_o (divz)
  );

  always #5 clk = ~clk;

  typedef struct {
    mdu_op_t      op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         zero;
    logic         divz;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive a request at the falling edge so it is sampled on the next rising edge.
  task automatic issue(input mdu_op_t o, input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Counts edges after acceptance until done, flagging any early busy drop or early done.
  task automatic wait_done(output int edges, output bit busy_ok);
    edges = 0;
    busy_ok = 1'b1;
    while (edges < 200) begin
      @(posedge clk);
      #1 edges++;
      if (done) break;
      if (!busy) busy_ok = 1'b0;
    end
  endtask

  task automatic check_result(input string tag, input vec_t v, input int edges, input bit busy_ok);
    chk({tag, " latency"}, 64'(edges), 64'(LAT));
    chk({tag, " busy_during"}, 64'(busy_ok), 64'd1);
    chk({tag, " busy_at_done"}, 64'(busy), 64'd0);
    chk({tag, " hi"}, 64'(hi), 64'(v.hi));
    chk({tag, " lo"}, 64'(lo), 64'(v.lo));
    chk({tag, " zero"}, 64'(zero), 64'(v.zero));
    chk({tag, " divz"}, 64'(divz), 64'(v.divz));
    $display("txn %s op=%s a=%h b=%h -> hi=%h lo=%h zero=%0d divz=%0d edges=%0d",
             tag, v.op.name(), v.a, v.b, hi, lo, zero, divz, edges);
  endtask

  initial begin
    int   edges;
    bit   busy_ok;
    vec_t v;

    vecs[0]  = '{MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 1'b0};
    vecs[1]  = '{MDU_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 1'b0};
    vecs[2]  = '{MDU_MULTU, 32'h00000000, 32'h00000005, 32'h00000000, 32'h00000000, 1'b1, 1'b0};
    vecs[3]  = '{MDU_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b0};
    vecs[4]  = '{MDU_DIVU,  32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 1'b0, 1'b0};
    vecs[5]  = '{MDU_DIVU,  32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF, 1'b0, 1'b1};
    vecs[6]  = '{MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 1'b0};
    vecs[7]  = '{MDU_MULT,  32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000000, 32'h00000006, 1'b0, 1'b0};
    vecs[8]  = '{MDU_DIV,   32'hFFFFFFF0, 32'h00000000, 32'hFFFFFFF0, 32'hFFFFFFFF, 1'b0, 1'b1};
    vecs[9]  = '{MDU_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b1, 1'b0};
    vecs[10] = '{MDU_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 1'b0};
    vecs[11] = '{MDU_DIVU,  32'hFFFFFFFF, 32'h0000000A, 32'h00000005, 32'h19999999, 1'b0, 1'b0};

    rst = 1'b1; start = 1'b0; op = MDU_MULT; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset hi_lo", {hi, lo}, 64'd0);
    chk("reset flags", {62'd0, zero, divz}, 64'd0);
    @(negedge clk) rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      chk($sformatf("v%0d busy_after_start", i), 64'(busy), 64'd1);
      wait_done(edges, busy_ok);
      check_result($sformatf("v%0d", i), vecs[i], edges, busy_ok);
      @(posedge clk);
      #1 chk($sformatf("v%0d done_pulse", i), 64'(done), 64'd0);
      chk($sformatf("v%0d hold_lo", i), 64'(lo), 64'(vecs[i].lo));
    end

    // Start while busy is ignored; start on the done cycle is accepted.
    issue(MDU_MULTU, 32'd3, 32'd4);
    repeat (5) @(posedge clk);
    @(negedge clk);
    start = 1'b1; op = MDU_DIVU; a = 32'd9; b = 32'd3;
    @(posedge clk);
    #1 start = 1'b0;
    chk("ign busy", 64'(busy), 64'd1);
    wait_done(edges, busy_ok);
    v = '{MDU_MULTU, 32'd3, 32'd4, 32'h0, 32'hC, 1'b0, 1'b0};
    check_result("ignored_start", v, edges + 6, busy_ok);
    start = 1'b1; op = MDU_DIVU; a = 32'd9; b = 32'd3;
    @(posedge clk);
    #1 start = 1'b0;
    chk("b2b busy", 64'(busy), 64'd1);
    chk("b2b done_drop", 64'(done), 64'd0);
    chk("b2b hold_lo", 64'(lo), 64'hC);
    wait_done(edges, busy_ok);
    v = '{MDU_DIVU, 32'd9, 32'd3, 32'h0, 32'h3, 1'b0, 1'b0};
    check_result("back_to_back", v, edges, busy_ok);

    // Reset mid-operation clears everything at once.
    issue(MDU_DIV, 32'hFFFFFF9C, 32'd7);
    repeat (9) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    #1;
    chk("abort busy", 64'(busy), 64'd0);
    chk("abort done", 64'(done), 64'd0);
    chk("abort hi_lo", {hi, lo}, 64'd0);
    chk("abort flags", {62'd0, zero, divz}, 64'd0);
    @(negedge clk) rst = 1'b0;
    issue(MDU_DIVU, 32'd10, 32'd3);
    wait_done(edges, busy_ok);
    v = '{MDU_DIVU, 32'd10, 32'd3, 32'h1, 32'h3, 1'b0, 1'b0};
    check_result("after_abort", v, edges, busy_ok);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
